// File: rtl/dwt_line_sequencer.sv
// Vertical DWT line sequencer: reads row pairs in symmetric-extension order from a
// dual-read-port frame buffer and streams {odd, even} beats with sof/eol framing.
//
// state | meaning
// IDLE  | waiting for a start with a legal tile configuration
// RUN   | issuing frame-buffer reads, one beat per read
// DRAIN | all reads issued; emptying the output FIFO
module dwt_line_sequencer #(
  parameter int DataWidth       = 24,
  parameter int MaximumSideSize = 32,
  parameter int AddrWidth       = $clog2(MaximumSideSize)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth:0]     width_i,
  input  logic [AddrWidth:0]     height_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   rd_en_o,
  output logic [AddrWidth-1:0]   rd_even_row_o,
  output logic [AddrWidth-1:0]   rd_odd_row_o,
  output logic [AddrWidth-1:0]   rd_col_o,
  input  logic [DataWidth-1:0]   rd_even_data_i,
  input  logic [DataWidth-1:0]   rd_odd_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int CW = AddrWidth + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  cnt_t                   w_q, h_q, pair_q;
  logic [AddrWidth-1:0]   col_q;
  logic                   rd_pend_q, pend_sof_q, pend_eol_q;
  logic [2*DataWidth+1:0] fifo_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;
  logic                   done_q, err_q;

  logic                   cfg_ok, start_ok, start_bad, finish;
  logic                   last_col, last_pair, push, pop, rd_en;
  logic [2:0]             occ_after;
  cnt_t                   half, k;
  logic [AddrWidth-1:0]   even_row, odd_row;
  logic [2*DataWidth+1:0] head;

  assign cfg_ok = !height_i[0] && (height_i >= cnt_t'(6)) &&
                  (height_i <= cnt_t'(MaximumSideSize)) &&
                  (width_i != '0) && (width_i <= cnt_t'(MaximumSideSize));

  assign half      = h_q >> 1;
  assign last_col  = ({1'b0, col_q} == (w_q - cnt_t'(1)));
  assign last_pair = (pair_q == (half + cnt_t'(3)));

  assign push      = rd_pend_q;
  assign m_valid_o = (count_q != 2'd0);
  assign pop       = m_valid_o & m_ready_i;

  // A pop in this cycle frees its slot, which keeps back-to-back streaming at 1 beat/cycle.
  assign occ_after = {1'b0, count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_en     = (state_q == RUN) && (occ_after < 3'd2);

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            start_ok = 1'b1;
            state_d  = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_en && last_col && last_pair) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (count_q == 2'd1) && !rd_pend_q) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Symmetric extension: two mirrored pairs ahead of the tile and two behind it.
  always_comb begin
    k        = pair_q - cnt_t'(2);
    even_row = AddrWidth'({k, 1'b0});
    odd_row  = AddrWidth'({k, 1'b1});
    if (pair_q == cnt_t'(0)) begin
      even_row = AddrWidth'(4);
      odd_row  = AddrWidth'(3);
    end else if (pair_q == cnt_t'(1)) begin
      even_row = AddrWidth'(2);
      odd_row  = AddrWidth'(1);
    end else if (pair_q == (half + cnt_t'(2))) begin
      even_row = AddrWidth'(h_q - cnt_t'(2));
      odd_row  = AddrWidth'(h_q - cnt_t'(3));
    end else if (pair_q == (half + cnt_t'(3))) begin
      even_row = AddrWidth'(h_q - cnt_t'(4));
      odd_row  = AddrWidth'(h_q - cnt_t'(5));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      pair_q     <= '0;
      col_q      <= '0;
      rd_pend_q  <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_eol_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= finish;
      err_q      <= start_bad;
      if (start_ok) begin
        w_q    <= width_i;
        h_q    <= height_i;
        pair_q <= '0;
        col_q  <= '0;
      end else if (rd_en) begin
        if (last_col) begin
          col_q  <= '0;
          pair_q <= pair_q + cnt_t'(1);
        end else begin
          col_q  <= col_q + AddrWidth'(1);
        end
      end
      rd_pend_q  <= rd_en;
      pend_sof_q <= rd_en && (pair_q == '0) && (col_q == '0);
      pend_eol_q <= rd_en && last_col;
      if (push) begin
        fifo_q[wr_ptr_q] <= {pend_sof_q, pend_eol_q, rd_odd_data_i, rd_even_data_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign m_data_o      = m_valid_o ? head[2*DataWidth-1:0] : '0;
  assign m_sof_o       = m_valid_o & head[2*DataWidth+1];
  assign m_eol_o       = m_valid_o & head[2*DataWidth];
  assign rd_en_o       = rd_en;
  assign rd_even_row_o = rd_en ? even_row : '0;
  assign rd_odd_row_o  = rd_en ? odd_row : '0;
  assign rd_col_o      = rd_en ? col_q : '0;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
